// File: rtl/user_id_pkg.sv
// ---------------------------------------------------------------------------
// user_id_pkg
// Shared definitions for the user ID reader:
//   - state_t            : reader FSM states
//   - DEFAULT_ID_WIDTH   : default width of the user project ID word
//   - DEFAULT_CLK_DIV    : default number of clk cycles per serial bit
//   - DEFAULT_MAX_RETRY  : default number of capture attempts before the ID
//                          is declared unstable
// ---------------------------------------------------------------------------
package user_id_pkg;

  localparam int DEFAULT_ID_WIDTH  = 32;
  localparam int DEFAULT_CLK_DIV   = 4;
  localparam int DEFAULT_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAP_A = 3'd1,
    CAP_B = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : user_id_pkg

// File: rtl/user_id_bit_timer.sv
// ---------------------------------------------------------------------------
// user_id_bit_timer
// Bit-period timer for the serial ID output. A down-counter that paces the
// serial bits: tick is high on the last clk cycle of every CLK_DIV-cycle bit
// period while enable is high. The counter is held at zero whenever enable
// is low, so every SHIFT phase starts with a full bit period.
//
// Parameters:
//   CLK_DIV  clk cycles per serial bit, 1..255
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   enable   in   high while the reader is shifting
//   tick     out  one-cycle pulse on the last cycle of each bit period
// ---------------------------------------------------------------------------
module user_id_bit_timer
  import user_id_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt;
  logic [7:0] remaining;

  // A count of zero means "fresh bit period", so the idle/cleared value of
  // the counter is zero while the first period still lasts CLK_DIV cycles.
  assign remaining = (cnt == 8'd0) ? 8'(CLK_DIV) : cnt;
  assign tick      = enable && (remaining == 8'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 8'd0;
    end else if (!enable || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= remaining - 8'd1;
    end
  end

endmodule : user_id_bit_timer

// File: rtl/user_id_reader.sv
// ---------------------------------------------------------------------------
// user_id_reader
// Reads the static user project ID word, checks that it is stable by
// sampling it on two consecutive cycles, and serializes the stable value MSB
// first on sdo with one sdo_strobe pulse per bit. If the two samples keep
// disagreeing for MAX_RETRY attempts, id_err is set (sticky until the next
// stable read or reset), id_value is left untouched and no bits are shifted.
//
// Optional feature (compile-time macro):
//   USER_ID_PARITY_EN  append one even-parity bit (XOR of the ID) after
//                      bit 0, with its own strobe
//
// Parameters:
//   ID_WIDTH   width of the user ID word
//   CLK_DIV    clk cycles per serial bit, 1..255
//   MAX_RETRY  capture attempts before reporting an unstable ID
// Ports:
//   clk         in   sole clock, rising edge
//   resetn      in   asynchronous active-low reset
//   mask_rev    in   static user ID word from the ID programming cells
//   rd_req      in   level request; sampled only in IDLE
//   rd_busy     out  high in every state except IDLE
//   id_value    out  last stable captured ID
//   sdo         out  serial ID bit, MSB first; 0 outside SHIFT
//   sdo_strobe  out  one-cycle pulse on the last clk of each bit period
//   rd_done     out  one-cycle completion pulse
//   id_err      out  sticky unstable-capture flag
// ---------------------------------------------------------------------------
module user_id_reader
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH  = DEFAULT_ID_WIDTH,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                rd_req,
  output logic                rd_busy,
  output logic [ID_WIDTH-1:0] id_value,
  output logic                sdo,
  output logic                sdo_strobe,
  output logic                rd_done,
  output logic                id_err
);

`ifdef USER_ID_PARITY_EN
  localparam int NUM_BITS = ID_WIDTH + 1;
`else
  localparam int NUM_BITS = ID_WIDTH;
`endif
  localparam int BIT_W   = $clog2(NUM_BITS + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(NUM_BITS - 1);
  localparam logic [RETRY_W-1:0] LAST_RETRY = RETRY_W'(MAX_RETRY - 1);

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] cap_a, cap_a_next;
  logic [ID_WIDTH-1:0] cap_b;
  logic [ID_WIDTH-1:0] id_value_next;
  logic                id_err_next;
  logic [RETRY_W-1:0]  retry_cnt, retry_next;
  logic [NUM_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic                shift_active;
  logic                bit_tick;

  // Sample B is taken on the CAP_B edge and consumed on that same edge, so
  // it is compared straight from the input rather than through a flop.
  assign cap_b = mask_rev;

  assign shift_active = (state == SHIFT);

  user_id_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk    (clk),
    .resetn (resetn),
    .enable (shift_active),
    .tick   (bit_tick)
  );

  // State and datapath registers; everything returns to zero on reset so an
  // aborted read leaves no trace except the cleared outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cap_a     <= '0;
      id_value  <= '0;
      id_err    <= 1'b0;
      retry_cnt <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_next;
      cap_a     <= cap_a_next;
      id_value  <= id_value_next;
      id_err    <= id_err_next;
      retry_cnt <= retry_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_next;
    end
  end

  // Next-state and datapath logic. The shift register is loaded together
  // with id_value on a stable capture, so SHIFT only ever moves bits out.
  always_comb begin
    state_next    = state;
    cap_a_next    = cap_a;
    id_value_next = id_value;
    id_err_next   = id_err;
    retry_next    = retry_cnt;
    shift_next    = shift_reg;
    bit_next      = bit_cnt;

    case (state)
      IDLE: begin
        if (rd_req) begin
          state_next = CAP_A;
          retry_next = '0;
          bit_next   = '0;
        end
      end

      CAP_A: begin
        cap_a_next = mask_rev;
        state_next = CAP_B;
      end

      CAP_B: begin
        if (cap_a == cap_b) begin
          id_value_next = cap_a;
          id_err_next   = 1'b0;
`ifdef USER_ID_PARITY_EN
          shift_next    = {cap_a, ^cap_a};
`else
          shift_next    = cap_a;
`endif
          bit_next      = '0;
          state_next    = SHIFT;
        end else begin
          retry_next = retry_cnt + RETRY_W'(1);
          if (retry_cnt == LAST_RETRY) begin
            id_err_next = 1'b1;
            state_next  = DONE;
          end else begin
            state_next = CAP_A;
          end
        end
      end

      SHIFT: begin
        // The bit counter stops at the last bit instead of wrapping; it is
        // only rewound when a new sequence starts or DONE is reached.
        if (bit_tick) begin
          shift_next = shift_reg << 1;
          if (bit_cnt == LAST_BIT) begin
            state_next = DONE;
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end
      end

      DONE: begin
        retry_next = '0;
        bit_next   = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_busy    = (state != IDLE);
  assign rd_done    = (state == DONE);
  assign sdo        = shift_active & shift_reg[NUM_BITS-1];
  assign sdo_strobe = bit_tick;

endmodule : user_id_reader

// File: tb/tb_user_id_reader.sv
// ---------------------------------------------------------------------------
// tb_user_id_reader
// Self-checking bench for user_id_reader. Two instances share clock, reset
// and mask_rev: one with CLK_DIV=1 and one with CLK_DIV=4. Expected serial
// bits are queued when a read is started and popped on every sdo_strobe.
// Build with +define+USER_ID_PARITY_EN to exercise the parity bit.
// ---------------------------------------------------------------------------
module tb_user_id_reader;

`ifdef USER_ID_PARITY_EN
  localparam int NBITS = 33;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 32;
  localparam bit PAR   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mask_rev;
  logic        rd_req1, rd_req4;

  logic        busy1, sdo1, stb1, done1, err1;
  logic [31:0] idv1;
  logic        busy4, sdo4, stb4, done4, err4;
  logic [31:0] idv4;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  int   busy_cnt;
  int   bit_k;
  int   strobe_cnt;
  logic last_bit;

  always #5 clk = ~clk;

  user_id_reader #(.ID_WIDTH(32), .CLK_DIV(1), .MAX_RETRY(3)) dut1 (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev), .rd_req(rd_req1),
    .rd_busy(busy1), .id_value(idv1), .sdo(sdo1), .sdo_strobe(stb1),
    .rd_done(done1), .id_err(err1)
  );

  user_id_reader #(.ID_WIDTH(32), .CLK_DIV(4), .MAX_RETRY(3)) dut4 (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev), .rd_req(rd_req4),
    .rd_busy(busy4), .id_value(idv4), .sdo(sdo4), .sdo_strobe(stb4),
    .rd_done(done4), .id_err(err4)
  );

  function automatic int exp_latency(input int div);
    return 3 + 32 * div + (PAR ? div : 0);
  endfunction

  function automatic logic get_done(input int div);
    return (div == 1) ? done1 : done4;
  endfunction

  function automatic logic get_busy(input int div);
    return (div == 1) ? busy1 : busy4;
  endfunction

  function automatic logic get_err(input int div);
    return (div == 1) ? err1 : err4;
  endfunction

  function automatic logic [31:0] get_idv(input int div);
    return (div == 1) ? idv1 : idv4;
  endfunction

  task automatic push_id(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) exp_q.push_back(v[i]);
    if (PAR) exp_q.push_back(^v);
  endtask

  // Scoreboard step, called once per cycle at the falling edge.
  task automatic sb_step(input int div);
    logic b, s, st, e;
    b  = get_busy(div);
    s  = (div == 1) ? sdo1 : sdo4;
    st = (div == 1) ? stb1 : stb4;
    if (!b) begin
      busy_cnt = 0;
      bit_k    = 0;
    end else begin
      busy_cnt++;
    end
    if (st) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL strobe_unexpected: strobe at busy cycle %0d, required none", busy_cnt);
      end else begin
        e = exp_q.pop_front();
        last_bit = s;
        if (s !== e) begin
          errors++;
          $display("[TB] FAIL sdo_bit%0d: got %0b, required %0b", bit_k, s, e);
        end
        checks++;
        if (busy_cnt !== 2 + (bit_k + 1) * div) begin
          errors++;
          $display("[TB] FAIL strobe_timing bit%0d: at busy cycle %0d, required %0d",
                   bit_k, busy_cnt, 2 + (bit_k + 1) * div);
        end
      end
      bit_k++;
      strobe_cnt++;
    end else if (b && busy_cnt > 2 && bit_k < NBITS && exp_q.size() > 0) begin
      checks++;
      if (s !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL sdo_hold bit%0d: got %0b, required %0b", bit_k, s, exp_q[0]);
      end
    end else begin
      checks++;
      if (s !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sdo_idle: got %0b, required 0 at busy cycle %0d", s, busy_cnt);
      end
    end
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    rd_req1  = 1'b0;
    rd_req4  = 1'b0;
    mask_rev = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, sdo1, stb1, done1, err1, idv1} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut1: got busy=%0b sdo=%0b stb=%0b done=%0b err=%0b id=%h, required all 0",
               busy1, sdo1, stb1, done1, err1, idv1);
    end
    checks++;
    if ({busy4, sdo4, stb4, done4, err4, idv4} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut4: got busy=%0b sdo=%0b stb=%0b done=%0b err=%0b id=%h, required all 0",
               busy4, sdo4, stb4, done4, err4, idv4);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stable(input int div, input logic [31:0] val);
    int done_cyc;
    int lim;
    mask_rev   = val;
    push_id(val);
    strobe_cnt = 0;
    busy_cnt   = 0;
    bit_k      = 0;
    done_cyc   = 0;
    lim        = exp_latency(div) + 20;
    if (div == 1) rd_req1 = 1'b1; else rd_req4 = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rd_req1 = 1'b0;
        rd_req4 = 1'b0;
      end
      sb_step(div);
      if (get_done(div)) begin
        done_cyc = c;
        break;
      end
    end
    checks++;
    if (done_cyc !== exp_latency(div)) begin
      errors++;
      $display("[TB] FAIL done_cycle div%0d: got %0d, required %0d", div, done_cyc, exp_latency(div));
    end
    checks++;
    if (strobe_cnt !== NBITS) begin
      errors++;
      $display("[TB] FAIL strobe_count div%0d: got %0d, required %0d", div, strobe_cnt, NBITS);
    end
    checks++;
    if (get_idv(div) !== val) begin
      errors++;
      $display("[TB] FAIL id_value div%0d: got %h, required %h", div, get_idv(div), val);
    end
    checks++;
    if (get_err(div) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL id_err_clear div%0d: got %0b, required 0", div, get_err(div));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bits_left div%0d: got %0d, required 0", div, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    sb_step(div);
    checks++;
    if (get_done(div) !== 1'b0 || get_busy(div) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse div%0d: got done=%0b busy=%0b, required 0 0",
               div, get_done(div), get_busy(div));
    end
  endtask

  task automatic test_unstable(input logic [31:0] prior);
    int done_cyc;
    mask_rev   = 32'h0F0F0F0F;
    strobe_cnt = 0;
    busy_cnt   = 0;
    bit_k      = 0;
    done_cyc   = 0;
    rd_req1    = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      mask_rev = ~mask_rev;
      if (c == 1) rd_req1 = 1'b0;
      sb_step(1);
      if (done1) begin
        done_cyc = c;
        break;
      end
    end
    checks++;
    if (done_cyc !== 7) begin
      errors++;
      $display("[TB] FAIL unstable_done_cycle: got %0d, required 7", done_cyc);
    end
    checks++;
    if (err1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unstable_id_err: got %0b, required 1", err1);
    end
    checks++;
    if (strobe_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL unstable_strobes: got %0d, required 0", strobe_cnt);
    end
    checks++;
    if (idv1 !== prior) begin
      errors++;
      $display("[TB] FAIL unstable_id_value: got %h, required %h", idv1, prior);
    end
    mask_rev = 32'h12345678;
    repeat (3) @(negedge clk);
    checks++;
    if (err1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL id_err_sticky: got err=%0b busy=%0b, required 1 0", err1, busy1);
    end
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    mask_rev   = 32'h3C5A96E1;
    push_id(32'h3C5A96E1);
    strobe_cnt = 0;
    busy_cnt   = 0;
    bit_k      = 0;
    saw_done   = 1'b0;
    rd_req1    = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) rd_req1 = 1'b0;
      sb_step(1);
    end
    checks++;
    if (strobe_cnt !== 11) begin
      errors++;
      $display("[TB] FAIL abort_prefix_strobes: got %0d, required 11", strobe_cnt);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy1, sdo1, stb1, done1, err1, idv1} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got busy=%0b sdo=%0b stb=%0b done=%0b err=%0b id=%h, required all 0",
               busy1, sdo1, stb1, done1, err1, idv1);
    end
    repeat (3) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    resetn = 1'b1;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done_seen=%0b busy=%0b, required 0 0", saw_done, busy1);
    end
    test_stable(1, 32'h5A3CF07E);
  endtask

  task automatic test_back_to_back(input logic [31:0] v1, input logic [31:0] v2);
    int l;
    int d1, d2;
    logic exp_last;
    l          = exp_latency(1);
    d1         = 0;
    d2         = 0;
    exp_last   = PAR ? ^v2 : v2[0];
    mask_rev   = v1;
    push_id(v1);
    push_id(v2);
    strobe_cnt = 0;
    busy_cnt   = 0;
    bit_k      = 0;
    rd_req1    = 1'b1;
    for (int c = 1; c <= 2 * l + 20; c++) begin
      @(negedge clk);
      if (c == 5) mask_rev = v2;
      if (c == l + 2) rd_req1 = 1'b0;
      sb_step(1);
      if (done1) begin
        if (d1 == 0) begin
          d1 = c;
        end else begin
          d2 = c;
          break;
        end
      end
    end
    rd_req1 = 1'b0;
    checks++;
    if (d1 !== l) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got %0d, required %0d", d1, l);
    end
    checks++;
    if (d2 !== 2 * l + 1) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: got %0d, required %0d", d2, 2 * l + 1);
    end
    checks++;
    if (strobe_cnt !== 2 * NBITS) begin
      errors++;
      $display("[TB] FAIL b2b_strobes: got %0d, required %0d", strobe_cnt, 2 * NBITS);
    end
    checks++;
    if (last_bit !== exp_last) begin
      errors++;
      $display("[TB] FAIL b2b_final_bit: got %0b, required %0b", last_bit, exp_last);
    end
    checks++;
    if (idv1 !== v2) begin
      errors++;
      $display("[TB] FAIL b2b_id_value: got %h, required %h", idv1, v2);
    end
    if (exp_q.size() != 0) exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

`ifdef USER_ID_PARITY_EN
  task automatic test_parity;
    test_stable(1, 32'h00000007);
    checks++;
    if (last_bit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_final_bit: got %0b, required 1", last_bit);
    end
  endtask
`endif

  initial begin
    last_bit = 1'b0;
    test_reset;
    test_stable(1, 32'hA5C30F81);
    test_stable(4, 32'hA5C30F81);
    test_unstable(32'hA5C30F81);
    test_reset_abort;
`ifdef USER_ID_PARITY_EN
    test_parity;
`endif
    test_back_to_back(32'h00000007, 32'h80000001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_user_id_reader
